// File: rtl/main_mem_responder.sv
// Main-memory responder for cache line refills and write-backs, with a fixed access latency.
// Optional define MAIN_MEM_STATS_EN adds the rd_line_cnt / wr_line_cnt completion counters.
module main_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int MEM_ADDR_LEN  = 8,
  parameter int LATENCY       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [MEM_ADDR_LEN-1:0] req_line_addr,
  input  logic                    wr_valid,
  input  logic [31:0]             wr_data,
  output logic                    rd_valid,
  output logic [31:0]             rd_data,
  output logic                    rd_last,
  output logic                    wr_done
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [31:0]             rd_line_cnt,
  output logic [31:0]             wr_line_cnt
`endif
);

  localparam int DEPTH = 1 << (MEM_ADDR_LEN + LINE_ADDR_LEN);
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);
  localparam logic [LINE_ADDR_LEN-1:0] LAST_IDX = LINE_ADDR_LEN'((1 << LINE_ADDR_LEN) - 1);

  typedef enum logic [2:0] {IDLE, WR_BURST, WAIT, RD_BURST, DONE} state_t;

  logic [31:0]              mem [DEPTH];
  state_t                   state;
  logic                     we_q;
  logic [MEM_ADDR_LEN-1:0]  line_q;
  logic [LINE_ADDR_LEN-1:0] idx;
  logic [7:0]               lat_cnt;
  logic                     mem_we;
  logic                     send_word;

  assign req_ready = (state == IDLE);
  assign mem_we    = (state == WR_BURST) && wr_valid;
  // A refill word goes out on the last latency edge and on every burst edge until rd_last.
  assign send_word = ((state == WAIT) && (lat_cnt == 8'd0) && !we_q) ||
                     ((state == RD_BURST) && !rd_last);

  // Storage is deliberately left out of reset so partial write-backs survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[{line_q, idx}] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      line_q   <= '0;
      idx      <= '0;
      lat_cnt  <= 8'd0;
      rd_valid <= 1'b0;
      rd_data  <= 32'd0;
      rd_last  <= 1'b0;
      wr_done  <= 1'b0;
`ifdef MAIN_MEM_STATS_EN
      rd_line_cnt <= 32'd0;
      wr_line_cnt <= 32'd0;
`endif
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            line_q  <= req_line_addr;
            idx     <= '0;
            lat_cnt <= LAT_LOAD;
            state   <= req_we ? WR_BURST : WAIT;
          end
        end
        WR_BURST: begin
          if (wr_valid) begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              lat_cnt <= LAT_LOAD;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (lat_cnt != 8'd0) begin
            lat_cnt <= lat_cnt - 8'd1;
          end else if (we_q) begin
            wr_done <= 1'b1;
            state   <= DONE;
`ifdef MAIN_MEM_STATS_EN
            wr_line_cnt <= wr_line_cnt + 32'd1;
`endif
          end else begin
            state <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (rd_last) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= 32'd0;
            state    <= IDLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (send_word) begin
        rd_valid <= 1'b1;
        rd_data  <= mem[{line_q, idx}];
        rd_last  <= (idx == LAST_IDX);
        idx      <= idx + 1'b1;
`ifdef MAIN_MEM_STATS_EN
        if (idx == LAST_IDX) rd_line_cnt <= rd_line_cnt + 32'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: table of line transactions, corner-case
// sequences (held request, reset mid-burst) and randomized traffic against a word-array model.
module tb_main_mem_responder;
  localparam int LAL = 3;
  localparam int MAL = 8;
  localparam int LAT = 8;
  localparam int N   = 1 << LAL;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid, req_ready, req_we;
  logic [MAL-1:0] req_line_addr;
  logic           wr_valid;
  logic [31:0]    wr_data;
  logic           rd_valid, rd_last, wr_done;
  logic [31:0]    rd_data;
`ifdef MAIN_MEM_STATS_EN
  logic [31:0]    rd_line_cnt, wr_line_cnt;
`endif

  main_mem_responder #(.LINE_ADDR_LEN(LAL), .MEM_ADDR_LEN(MAL), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_line_addr(req_line_addr),
    .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .wr_done(wr_done)
`ifdef MAIN_MEM_STATS_EN
    , .rd_line_cnt(rd_line_cnt), .wr_line_cnt(wr_line_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_rd_lines = 0;
  int exp_wr_lines = 0;

  logic [31:0] model [N << MAL];
  bit          known [N << MAL];

  typedef struct {
    bit          we;
    logic [7:0]  line;
    logic [31:0] base;   // write: word k = base+k; read: expected word k = base+k
    int          gap;    // 0 back-to-back, 1 alternating 1-0-1-0
  } vec_t;
  vec_t tab [8];

  typedef struct {
    int          t;
    logic [31:0] d;
    logic        last;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int widx(input logic [7:0] line, input int w);
    return int'(line) * N + w;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait_bound", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic reset_now();
    rst = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
    chk("rst_rd_last", {31'd0, rd_last}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    wr_valid = 1'b0;
    exp_rd_lines = 0;
    exp_wr_lines = 0;
  endtask

  // gap: 0 none, 1 alternating, 2 random gaps
  task automatic do_write(input logic [7:0] line, input logic [31:0] base, input bit rnd, input int gap);
    int pulses = 0;
    int first = -1;
    logic [31:0] d;
    wr_valid = 1'b0;
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_line_addr = line;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
    for (int k = 0; k < N; k++) begin
      if ((gap == 1 && k > 0) || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        wr_valid = 1'b0;
        wr_data = $urandom;
        repeat ((gap == 2) ? $urandom_range(1, 3) : 1) tick();
      end
      d = rnd ? $urandom : base + 32'(k);
      wr_valid = 1'b1; wr_data = d;
      tick();
      model[widx(line, k)] = d;
      known[widx(line, k)] = 1'b1;
    end
    for (int t = 1; t <= LAT + 3; t++) begin
      // junk write strobes while not bursting must not touch storage
      wr_valid = t <= LAT + 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_data = $urandom;
      tick();
      if (wr_done) begin
        pulses++;
        if (first < 0) first = t;
      end
      if (t == LAT + 1) chk("wr_ready_after_done", {31'd0, req_ready}, 32'd1);
    end
    wr_valid = 1'b0;
    chk("wr_done_pulses", 32'(pulses), 32'd1);
    chk("wr_done_delay", 32'(first), 32'(LAT));
    exp_wr_lines++;
  endtask

  task automatic do_read(input logic [7:0] line, input bit use_tab, input logic [31:0] base);
    int w;
    logic [31:0] e;
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_line_addr = line;
    tick();
    req_valid = 1'b0;
    for (int t = 1; t <= LAT + N + 1; t++) begin
      tick();
      if (t >= LAT && t < LAT + N) begin
        w = t - LAT;
        e = use_tab ? base + 32'(w) : model[widx(line, w)];
        chk($sformatf("rd_valid t%0d", t), {31'd0, rd_valid}, 32'd1);
        if (use_tab || known[widx(line, w)])
          chk($sformatf("rd_data line%0d w%0d", line, w), rd_data, e);
        chk($sformatf("rd_last w%0d", w), {31'd0, rd_last}, {31'd0, w == N - 1});
        chk("rd_busy", {31'd0, req_ready}, 32'd0);
      end else begin
        chk($sformatf("rd_idle_valid t%0d", t), {31'd0, rd_valid}, 32'd0);
        chk($sformatf("rd_ready t%0d", t), {31'd0, req_ready}, {31'd0, t >= LAT + N});
      end
    end
    exp_rd_lines++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t q[$];
    obs_t o;
    int accept_t;
    logic [7:0] rl;

    tab[0] = '{1'b1, 8'd5,   32'h100,  0};
    tab[1] = '{1'b0, 8'd5,   32'h100,  0};
    tab[2] = '{1'b1, 8'd254, 32'hFE00, 0};
    tab[3] = '{1'b1, 8'd0,   32'h0A00, 0};
    tab[4] = '{1'b1, 8'd255, 32'hFF00, 1};
    tab[5] = '{1'b0, 8'd255, 32'hFF00, 0};
    tab[6] = '{1'b0, 8'd254, 32'hFE00, 0};
    tab[7] = '{1'b0, 8'd0,   32'h0A00, 0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_line_addr = '0;
    wr_valid = 1'b0; wr_data = '0;
    repeat (3) tick();
    chk("init_req_ready", {31'd0, req_ready}, 32'd1);
    chk("init_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("init_wr_done", {31'd0, wr_done}, 32'd0);
    chk("init_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      if (tab[i].we) do_write(tab[i].line, tab[i].base, 1'b0, tab[i].gap);
      else           do_read(tab[i].line, 1'b1, tab[i].base);
    end

    // Request held through a busy refill; the changed address is the second request.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_line_addr = 8'd5;
    tick();
    req_line_addr = 8'd255;
    accept_t = -1;
    for (int t = 1; t <= 2 * (LAT + N) + 6; t++) begin
      tick();
      if (rd_valid) begin
        o.t = t; o.d = rd_data; o.last = rd_last;
        q.push_back(o);
      end
      if (t == accept_t) req_valid = 1'b0;
      if (req_ready && accept_t < 0) accept_t = t + 1;
    end
    req_valid = 1'b0;
    chk("hold_accept_edge", 32'(accept_t), 32'(LAT + N + 1));
    chk("hold_word_count", 32'(q.size()), 32'(2 * N));
    for (int k = 0; k < q.size() && k < 2 * N; k++) begin
      chk($sformatf("hold_t k%0d", k), 32'(q[k].t), k < N ? 32'(LAT + k) : 32'(2 * LAT + N + 1 + (k - N)));
      chk($sformatf("hold_d k%0d", k), q[k].d, k < N ? 32'h100 + 32'(k) : 32'hFF00 + 32'(k - N));
      chk($sformatf("hold_last k%0d", k), {31'd0, q[k].last}, {31'd0, (k % N) == N - 1});
    end
    exp_rd_lines += 2;

    // Reset during a write-back after 3 words: words 0-2 new, 3-7 keep old contents.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_line_addr = 8'd5;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1; wr_data = 32'hBAD0 + 32'(k);
      tick();
      model[widx(8'd5, k)] = 32'hBAD0 + 32'(k);
    end
    reset_now();
    do_read(8'd5, 1'b0, 32'd0);
    chk("partial_w2", model[widx(8'd5, 2)], 32'hBAD2);
    chk("partial_w3", model[widx(8'd5, 3)], 32'h103);

    // Reset during a refill burst.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_line_addr = 8'd255;
    tick();
    req_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("mid_read_valid", {31'd0, rd_valid}, 32'd1);
    reset_now();
    do_read(8'd255, 1'b1, 32'hFF00);

    for (int i = 0; i < 24; i++) begin
      rl = 8'($urandom_range(16, 31));
      if ($urandom_range(0, 1) == 1 || !known[widx(rl, 0)]) do_write(rl, 32'd0, 1'b1, 2);
      else do_read(rl, 1'b0, 32'd0);
    end

    // Completion counters since the last reset.
`ifdef MAIN_MEM_STATS_EN
    reset_now();
    for (int i = 0; i < 2; i++) do_write(8'(40 + i), 32'h4000 + 32'(i * 16), 1'b0, 0);
    for (int i = 0; i < 3; i++) do_read(8'(40 + (i % 2)), 1'b0, 32'd0);
    chk("rd_line_cnt", rd_line_cnt, 32'(exp_rd_lines));
    chk("wr_line_cnt", wr_line_cnt, 32'(exp_wr_lines));
    chk("rd_line_cnt_3", 32'(exp_rd_lines), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
